// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder for the pipeline memory stage.
// Latches one access in IDLE, waits LATENCY cycles in BUSY, and completes in DONE.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 64,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic        stall,
  output logic        err
);

  localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wd_q;
  logic [31:0] rd_q;
  logic        err_q;

  logic [31:0] mem [DEPTH_WORDS];

  logic          fault;
  logic          complete;
  logic [AW-1:0] idx;

  always_comb begin
    fault    = (addr_q[1:0] != '0) || (addr_q[31:2] >= 30'(DEPTH_WORDS));
    idx      = addr_q[AW+1:2];
    complete = (state_q == BUSY) && req && (cnt_q == '0);
  end

  // Gated by rst so the hazard logic sees no hold while reset is asserted.
  assign stall = rst && req && (state_q != DONE);
  assign rd    = rd_q;
  assign err   = err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wd_q    <= '0;
      rd_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req) begin
            we_q    <= we;
            addr_q  <= addr;
            wd_q    <= wd;
            cnt_q   <= 4'(LATENCY - 1);
            state_q <= BUSY;
          end
        end
        BUSY: begin
          if (!req) begin
            state_q <= IDLE;
          end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            err_q   <= fault;
            state_q <= DONE;
            if (!we_q) begin
              rd_q <= fault ? '0 : mem[idx];
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Storage is deliberately outside the reset domain so contents survive reset.
  always_ff @(posedge clk) begin
    if (complete && we_q && !fault) begin
      mem[idx] <= wd_q;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one LATENCY=2 instance and one LATENCY=1 instance.
module tb_dmem_responder;

  logic        clk;
  logic        rst;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wd;
  logic        use2;

  logic        req1, req2;
  logic [31:0] rd1, rd2;
  logic        stall1, stall2, err1, err2;
  logic [31:0] rd_s;
  logic        stall_s, err_s;

  int unsigned n_tests;
  int unsigned n_fail;

  assign req1    = req && !use2;
  assign req2    = req && use2;
  assign rd_s    = use2 ? rd2 : rd1;
  assign stall_s = use2 ? stall2 : stall1;
  assign err_s   = use2 ? err2 : err1;

  dmem_responder #(.DEPTH_WORDS(64), .LATENCY(2)) u_dut_l2 (
    .clk(clk), .rst(rst), .req(req1), .we(we), .addr(addr), .wd(wd),
    .rd(rd1), .stall(stall1), .err(err1)
  );

  dmem_responder #(.DEPTH_WORDS(64), .LATENCY(1)) u_dut_l1 (
    .clk(clk), .rst(rst), .req(req2), .we(we), .addr(addr), .wd(wd),
    .rd(rd2), .stall(stall2), .err(err2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drives one access starting in IDLE; leaves req high on return (back-to-back capable).
  task automatic access(input string tag, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input int unsigned lat,
                        input logic [31:0] exp_rd, input logic exp_err);
    req = 1'b1; we = w; addr = a; wd = d;
    for (int unsigned i = 0; i <= lat; i++) begin
      @(negedge clk);
      check({tag, "_stall_hi"}, 32'(stall_s), 32'd1);
      @(posedge clk); #1;
      if (i == 0) begin
        we = ~w; addr = ~a; wd = ~d;
      end
    end
    @(negedge clk);
    check({tag, "_stall_done"}, 32'(stall_s), 32'd0);
    check({tag, "_rd"}, rd_s, exp_rd);
    check({tag, "_err"}, 32'(err_s), 32'(exp_err));
    @(posedge clk); #1;
  endtask

  task automatic idle_check(input string tag, input logic [31:0] exp_rd);
    req = 1'b0;
    @(negedge clk);
    check({tag, "_rd_hold"}, rd_s, exp_rd);
    check({tag, "_err_lo"}, 32'(err_s), 32'd0);
    check({tag, "_stall_lo"}, 32'(stall_s), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    n_tests = 0; n_fail = 0;
    use2 = 1'b0;
    rst = 1'b0; req = 1'b1; we = 1'b0; addr = '0; wd = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_stall", 32'(stall_s), 32'd0);
    check("rst_rd", rd_s, 32'd0);
    check("rst_err", 32'(err_s), 32'd0);
    req = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;

    access("st10", 1'b1, 32'h10, 32'hDEADBEEF, 2, 32'h0, 1'b0);
    access("ld10", 1'b0, 32'h10, 32'h0, 2, 32'hDEADBEEF, 1'b0);
    idle_check("after_ld10", 32'hDEADBEEF);
    access("st00", 1'b1, 32'h00, 32'hA5A50000, 2, 32'hDEADBEEF, 1'b0);
    access("st08", 1'b1, 32'h08, 32'h77777777, 2, 32'hDEADBEEF, 1'b0);
    access("st20", 1'b1, 32'h20, 32'h11111111, 2, 32'hDEADBEEF, 1'b0);
    access("stFC", 1'b1, 32'hFC, 32'h600DF00D, 2, 32'hDEADBEEF, 1'b0);
    idle_check("after_st", 32'hDEADBEEF);

    access("ld13_mis", 1'b0, 32'h13, 32'h0, 2, 32'h0, 1'b1);
    idle_check("after_mis", 32'h0);
    access("st100_oor", 1'b1, 32'h100, 32'hFFFFFFFF, 2, 32'h0, 1'b1);
    idle_check("after_oor", 32'h0);
    access("ld00", 1'b0, 32'h00, 32'h0, 2, 32'hA5A50000, 1'b0);
    access("ldFC", 1'b0, 32'hFC, 32'h0, 2, 32'h600DF00D, 1'b0);
    idle_check("after_ldFC", 32'h600DF00D);

    // Flush: req dropped in the second BUSY cycle of a store to 0x20.
    req = 1'b1; we = 1'b1; addr = 32'h20; wd = 32'h1234;
    @(negedge clk); check("fl_stall0", 32'(stall_s), 32'd1);
    @(posedge clk); #1;
    @(negedge clk); check("fl_stall1", 32'(stall_s), 32'd1);
    @(posedge clk); #1;
    req = 1'b0;
    @(negedge clk);
    check("fl_stall2", 32'(stall_s), 32'd0);
    check("fl_err2", 32'(err_s), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("fl_err3", 32'(err_s), 32'd0);
    check("fl_rd3", rd_s, 32'h600DF00D);
    @(posedge clk); #1;
    access("ld20", 1'b0, 32'h20, 32'h0, 2, 32'h11111111, 1'b0);

    // Reset asserted while a store to 0x08 is in BUSY.
    we = 1'b1; addr = 32'h08; wd = 32'h0BADC0DE;
    @(posedge clk); #1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rstbusy_stall", 32'(stall_s), 32'd0);
    check("rstbusy_rd", rd_s, 32'd0);
    check("rstbusy_err", 32'(err_s), 32'd0);
    @(posedge clk); #1;
    req = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    access("ld08", 1'b0, 32'h08, 32'h0, 2, 32'h77777777, 1'b0);
    access("ld10b", 1'b0, 32'h10, 32'h0, 2, 32'hDEADBEEF, 1'b0);
    idle_check("after_rst", 32'hDEADBEEF);

    // LATENCY=1 instance: back-to-back loads give stall 1,1,0,1,1,0.
    use2 = 1'b1;
    @(posedge clk); #1;
    access("l1_st04", 1'b1, 32'h04, 32'hCAFE0001, 1, 32'h0, 1'b0);
    access("l1_st08", 1'b1, 32'h08, 32'hCAFE0002, 1, 32'h0, 1'b0);
    access("l1_ld04", 1'b0, 32'h04, 32'h0, 1, 32'hCAFE0001, 1'b0);
    access("l1_ld08", 1'b0, 32'h08, 32'h0, 1, 32'hCAFE0002, 1'b0);
    idle_check("l1_after", 32'hCAFE0002);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 The module SHALL have parameter DEPTH_WORDS, default 64, meaning the number of 32-bit words of backing storage.
REQ-002 The module SHALL have parameter LATENCY, default 2, meaning wait cycles per access, legal range 1..15.
REQ-003 The module SHALL use one clock and an asynchronous, active-low reset, with ports named clk and rst.
REQ-004 Port: clk  input  1  rising-edge clock.
REQ-005 Port: rst  input  1  asynchronous active-low reset.
REQ-006 Port: req  input  1  memory-stage access valid (load or store).
REQ-007 Port: we  input  1  1 = store, 0 = load; qualified by req.
REQ-008 Port: addr  input  32  byte address from the memory-stage ALU result.
REQ-009 Port: wd  input  32  store data.
REQ-010 Port: rd  output  32  registered load data to writeback.
REQ-011 Port: stall  output  1  hold request to the pipeline hazard logic.
REQ-012 Port: err  output  1  one-cycle pulse flagging a faulted access.

Function
REQ-013 The FSM SHALL have states IDLE, BUSY and DONE, plus a 4-bit wait counter.
REQ-014 IDLE with req=1: latch we, addr and wd; load counter with LATENCY-1; go to BUSY.
REQ-015 IDLE with req=0: remain in IDLE with no side effects.
REQ-016 BUSY with counter>0 and req=1: decrement the counter and stay in BUSY.
REQ-017 BUSY with counter==0 and req=1: perform the access using the latched values, then go to DONE.
REQ-018 BUSY with req=0 (pipeline flush): abort; no memory write; rd unchanged; err=0; next state IDLE.
REQ-019 DONE: unconditionally go to IDLE; a new access SHALL NOT begin from DONE.
REQ-020 stall SHALL equal req AND (state != DONE), combinationally.
REQ-021 Each access SHALL therefore stall exactly LATENCY+1 cycles; stall=0 in the DONE cycle so the pipeline advances.
REQ-022 An access SHALL fault when latched addr[1:0]!=0 or latched addr[31:2]>=DEPTH_WORDS.
REQ-023 Store access: write mem[addr[31:2]] <= wd at the clock edge that leaves BUSY; a faulted store SHALL write nothing.
REQ-024 Load access: rd <= mem[addr[31:2]] at the same edge; a faulted load SHALL set rd <= 0.
REQ-025 rd SHALL hold its value through stores and idle cycles, and change only on load completion or reset.
REQ-026 err SHALL be 1 only during the DONE cycle of a faulted access, and 0 otherwise.
REQ-027 Changes to addr, wd or we during BUSY SHALL be ignored; the values latched in IDLE govern the access.
REQ-028 Back-to-back requests (req held high across DONE) SHALL start the next access in the cycle after DONE, i.e. from IDLE.

Reset
REQ-029 With rst=0, the module SHALL asynchronously enter state IDLE, clear the counter, and drive rd=0, err=0 and stall=0.
REQ-030 A reset asserted mid-BUSY SHALL abort the access with no memory write.
REQ-031 Memory contents SHALL NOT be cleared by reset.
REQ-032 After rst rises, the first request SHALL be accepted no earlier than the first rising clk edge with rst=1.

Verification
REQ-033 Store then load, LATENCY=2: req,we=1,addr=0x10,wd=0xDEADBEEF, then req,we=0,addr=0x10 -> stall high 3 cycles per access; rd=0xDEADBEEF in the load's DONE cycle; err=0.
REQ-034 Misaligned load addr=0x13 -> err pulses once in DONE; rd=0; stall low in DONE.
REQ-035 Out-of-range store addr=0x100 (DEPTH_WORDS=64) -> err=1 in DONE; a subsequent load of 0x0 returns its prior value unchanged.
REQ-036 Flush: store to 0x20 with wd=0x1234, req dropped during the second BUSY cycle -> FSM returns to IDLE; a later load of 0x20 returns the old value; err never 1.
REQ-037 Reset mid-BUSY during a store to 0x08 -> stall=0, rd=0 immediately, no write; memory words written earlier are preserved.
REQ-038 Back-to-back loads with req held high, LATENCY=1 -> stall pattern 1,1,0,1,1,0; rd updates in each DONE cycle.
